// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes, opcode constants and sequencer state encoding
// for the ALU issue/collect controller.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_MUL = 5'd2;
  localparam logic [4:0] ALU_DIV = 5'd3;
  localparam logic [4:0] ALU_MOD = 5'd4;
  localparam logic [4:0] ALU_AND = 5'd5;
  localparam logic [4:0] ALU_OR  = 5'd6;
  localparam logic [4:0] ALU_XOR = 5'd7;
  localparam logic [4:0] ALU_NOT = 5'd8;
  localparam logic [4:0] ALU_SHL = 5'd9;
  localparam logic [4:0] ALU_SHR = 5'd10;
  localparam logic [4:0] ALU_EQ  = 5'd11;
  localparam logic [4:0] ALU_NE  = 5'd12;
  localparam logic [4:0] ALU_GE  = 5'd13;
  localparam logic [4:0] ALU_GT  = 5'd14;
  localparam logic [4:0] ALU_LE  = 5'd15;
  localparam logic [4:0] ALU_LT  = 5'd16;
  localparam logic [4:0] ALU_NOP = 5'd17;
  localparam logic [4:0] ALU_IMM = 5'd18;

  localparam logic [5:0] OPC_REG_MAX  = 6'd16;
  localparam logic [5:0] OPC_IMM_BASE = 6'd32;
  localparam logic [5:0] OPC_IMM_MAX  = 6'd42;
  localparam logic [5:0] OPC_LI       = 6'd48;
  localparam logic [5:0] OPC_NOP      = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: ALU op, operand selects and result-routing flags.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [4:0] o_alu_op,
  output logic       o_imm_sel,
  output logic       o_zero_d1,
  output logic       o_is_multi,
  output logic       o_is_cmp,
  output logic       o_wb_en,
  output logic       o_illegal
);

  always_comb begin
    o_alu_op  = ALU_NOP;
    o_imm_sel = 1'b0;
    o_zero_d1 = 1'b0;
    o_illegal = 1'b0;
    // Register and immediate forms share the low 5 opcode bits as the ALU op.
    if (i_opcode <= OPC_REG_MAX) begin
      o_alu_op = i_opcode[4:0];
    end else if (i_opcode >= OPC_IMM_BASE && i_opcode <= OPC_IMM_MAX) begin
      o_alu_op  = i_opcode[4:0];
      o_imm_sel = 1'b1;
    end else if (i_opcode == OPC_LI) begin
      o_alu_op  = ALU_IMM;
      o_imm_sel = 1'b1;
      o_zero_d1 = 1'b1;
    end else if (i_opcode != OPC_NOP) begin
      o_illegal = 1'b1;
    end
  end

  always_comb begin
    o_is_multi = (o_alu_op >= ALU_MUL) && (o_alu_op <= ALU_MOD);
    o_is_cmp   = (o_alu_op >= ALU_EQ)  && (o_alu_op <= ALU_LT);
    o_wb_en    = (o_alu_op <= ALU_SHR) || (o_alu_op == ALU_IMM);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect sequencer for the ALU: IDLE accepts, EXEC waits, DONE holds the result.
// Optional divide-by-zero trap is enabled with ALU_DIVZERO_TRAP_EN.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_LAT = 2
) (
  input  logic               Fast_Clock,
  input  logic               Reset,
  input  logic               Instr_Valid,
  output logic               Instr_Ready,
  input  logic [5:0]         Opcode,
  input  logic signed [31:0] Reg_Data_1,
  input  logic signed [31:0] Reg_Data_2,
  input  logic [15:0]        Imm,
  output logic [4:0]         ALU_Op,
  output logic signed [31:0] Data_1,
  output logic signed [31:0] Data_2,
  input  logic signed [31:0] ALU_Result,
  input  logic               ALU_True,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic signed [31:0] Wb_Data,
  output logic               Wb_En,
  output logic               Branch_Taken,
  output logic               Illegal,
  output logic               Div_Zero
);

  localparam logic [3:0] LP_LAT = 4'(MULTI_LAT);

  state_t             r_state, w_next;
  logic [3:0]         r_cnt;
  logic [4:0]         r_op;
  logic signed [31:0] r_d1, r_d2, r_wb_data;
  logic               r_wb_pend, r_is_cmp, r_wb_en, r_branch, r_illegal;

  logic [4:0] w_dec_op;
  logic       w_imm_sel, w_zero_d1, w_is_multi, w_is_cmp, w_wb_en, w_illegal;
  logic       w_accept, w_capture, w_dz;

  alu_op_decode u_dec (
    .i_opcode   (Opcode),
    .o_alu_op   (w_dec_op),
    .o_imm_sel  (w_imm_sel),
    .o_zero_d1  (w_zero_d1),
    .o_is_multi (w_is_multi),
    .o_is_cmp   (w_is_cmp),
    .o_wb_en    (w_wb_en),
    .o_illegal  (w_illegal)
  );

`ifdef ALU_DIVZERO_TRAP_EN
  logic r_div_zero;
  assign w_dz     = ((r_op == ALU_DIV) || (r_op == ALU_MOD)) && (r_d2 == 32'sd0);
  assign Div_Zero = r_div_zero;

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset)                                     r_div_zero <= 1'b0;
    else if (w_capture)                            r_div_zero <= w_dz;
    else if (r_state == ST_DONE && Out_Ready)      r_div_zero <= 1'b0;
  end
`else
  assign w_dz     = 1'b0;
  assign Div_Zero = 1'b0;
`endif

  assign w_accept  = Instr_Valid && Instr_Ready;
  // A trapped divide skips the remaining wait and captures immediately.
  assign w_capture = (r_state == ST_EXEC) && ((r_cnt == 4'd0) || w_dz);

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_EXEC;
      ST_EXEC: if (w_capture) w_next = ST_DONE;
      ST_DONE: if (Out_Ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Instr_Ready = (r_state == ST_IDLE) && !Reset;
    Out_Valid   = (r_state == ST_DONE);
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      r_op      <= ALU_NOP;
      r_d1      <= '0;
      r_d2      <= '0;
      r_cnt     <= '0;
      r_wb_pend <= 1'b0;
      r_is_cmp  <= 1'b0;
      r_illegal <= 1'b0;
      r_wb_data <= '0;
      r_wb_en   <= 1'b0;
      r_branch  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= w_dec_op;
        r_d1      <= w_zero_d1 ? 32'sd0 : Reg_Data_1;
        r_d2      <= w_imm_sel ? signed'(sext16(Imm)) : Reg_Data_2;
        r_cnt     <= w_is_multi ? LP_LAT : 4'd0;
        r_wb_pend <= w_wb_en;
        r_is_cmp  <= w_is_cmp;
        r_illegal <= w_illegal;
      end
      if (r_state == ST_EXEC) begin
        if (w_capture) begin
          r_wb_data <= w_dz ? 32'sd0 : ALU_Result;
          r_wb_en   <= r_wb_pend && !w_dz;
          r_branch  <= r_is_cmp && ALU_True;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      if (r_state == ST_DONE && Out_Ready) r_illegal <= 1'b0;
    end
  end

  assign ALU_Op       = r_op;
  assign Data_1       = r_d1;
  assign Data_2       = r_d2;
  assign Wb_Data      = r_wb_data;
  assign Wb_En        = r_wb_en;
  assign Branch_Taken = r_branch;
  assign Illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, spec-level reference model,
// directed cases followed by randomized instructions.
module tb_alu_issue_ctrl;

  localparam int LAT = 2;

  logic               Fast_Clock = 1'b0;
  logic               Reset;
  logic               Instr_Valid, Instr_Ready;
  logic [5:0]         Opcode;
  logic signed [31:0] Reg_Data_1, Reg_Data_2;
  logic [15:0]        Imm;
  logic [4:0]         ALU_Op;
  logic signed [31:0] Data_1, Data_2, ALU_Result, Wb_Data;
  logic               ALU_True, Out_Valid, Out_Ready, Wb_En, Branch_Taken, Illegal, Div_Zero;

  int n_vec = 0;
  int n_err = 0;
  logic signed [31:0] last_wb;

  always #5 Fast_Clock = ~Fast_Clock;

  alu_issue_ctrl #(.MULTI_LAT(LAT)) dut (
    .Fast_Clock(Fast_Clock), .Reset(Reset),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Opcode(Opcode), .Reg_Data_1(Reg_Data_1), .Reg_Data_2(Reg_Data_2), .Imm(Imm),
    .ALU_Op(ALU_Op), .Data_1(Data_1), .Data_2(Data_2),
    .ALU_Result(ALU_Result), .ALU_True(ALU_True),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Wb_Data(Wb_Data), .Wb_En(Wb_En), .Branch_Taken(Branch_Taken),
    .Illegal(Illegal), .Div_Zero(Div_Zero)
  );

  // Behavioural ALU: {True, Result}
  function automatic logic [32:0] alu_eval(input logic [4:0] op,
                                           input logic signed [31:0] a, b);
    logic signed [31:0] r;
    logic t;
    r = 0;
    t = 1'b0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a * b;
      5'd3:  r = (b == 0) ? 0 : (b == -1) ? -a : a / b;
      5'd4:  r = (b == 0 || b == -1) ? 0 : a % b;
      5'd5:  r = a & b;
      5'd6:  r = a | b;
      5'd7:  r = a ^ b;
      5'd8:  r = ~a;
      5'd9:  r = a << b[4:0];
      5'd10: r = a >> b[4:0];
      5'd11: t = (a == b);
      5'd12: t = (a != b);
      5'd13: t = (a >= b);
      5'd14: t = (a > b);
      5'd15: t = (a <= b);
      5'd16: t = (a < b);
      5'd18: r = b;
      default: r = 0;
    endcase
    if (op >= 5'd11 && op <= 5'd16) r = {31'b0, t};
    else t = (r != 0);
    return {t, r};
  endfunction

  assign {ALU_True, ALU_Result} = alu_eval(ALU_Op, Data_1, Data_2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE (called #1 after a posedge) and collect its result.
  task automatic do_instr(input logic [5:0] opc, input logic signed [31:0] r1, r2,
                          input logic [15:0] imm, input int stall);
    logic [4:0] eop;
    logic signed [31:0] ed1, ed2, ewb, simm;
    logic eill, ewben, ebr, edz, etrue;
    logic [32:0] ar;
    int ecyc, k;
    simm = signed'({{16{imm[15]}}, imm});
    eill = 1'b0; ed1 = r1; ed2 = r2;
    if (opc <= 16) eop = opc[4:0];
    else if (opc >= 32 && opc <= 42) begin eop = 5'(opc - 6'd32); ed2 = simm; end
    else if (opc == 48) begin eop = 5'd18; ed1 = 0; ed2 = simm; end
    else begin eop = 5'd17; eill = (opc != 63); end
    ar = alu_eval(eop, ed1, ed2);
    ewb = ar[31:0]; etrue = ar[32];
    ewben = (eop <= 10) || (eop == 18);
    ebr = (eop >= 11 && eop <= 16) && etrue;
    edz = 1'b0;
    ecyc = (eop >= 2 && eop <= 4) ? 1 + LAT : 1;
`ifdef ALU_DIVZERO_TRAP_EN
    if ((eop == 3 || eop == 4) && ed2 == 0) begin edz = 1'b1; ewb = 0; ewben = 1'b0; ecyc = 1; end
`endif
    chk("instr_ready_idle", 32'(Instr_Ready), 32'd1);
    Instr_Valid = 1'b1; Opcode = opc; Reg_Data_1 = r1; Reg_Data_2 = r2; Imm = imm;
    @(posedge Fast_Clock); #1;
    Instr_Valid = 1'b0; Opcode = 6'($urandom); Reg_Data_1 = $urandom;
    Reg_Data_2 = $urandom; Imm = 16'($urandom);
    Out_Ready = 1'($urandom_range(0, 1));
    chk("alu_op", 32'(ALU_Op), 32'(eop));
    chk("data_1", Data_1, ed1);
    chk("data_2", Data_2, ed2);
    chk("illegal_exec", 32'(Illegal), 32'(eill));
    chk("instr_ready_busy", 32'(Instr_Ready), 32'd0);
    k = 0;
    while (!Out_Valid && k < 40) begin
      @(posedge Fast_Clock); #1;
      k++;
      if (!Out_Valid) Out_Ready = 1'($urandom_range(0, 1));
    end
    chk("latency", k, ecyc);
    Out_Ready = (stall == 0);
    last_wb = Wb_Data;
    chk("wb_data", Wb_Data, ewb);
    chk("wb_en", 32'(Wb_En), 32'(ewben));
    chk("branch", 32'(Branch_Taken), 32'(ebr));
    chk("illegal_done", 32'(Illegal), 32'(eill));
    chk("div_zero", 32'(Div_Zero), 32'(edz));
    for (int s = 0; s < stall; s++) begin
      @(posedge Fast_Clock); #1;
      chk("hold_valid", 32'(Out_Valid), 32'd1);
      chk("hold_wb", Wb_Data, ewb);
      chk("hold_ready", 32'(Instr_Ready), 32'd0);
      if (s == stall - 1) Out_Ready = 1'b1;
    end
    @(posedge Fast_Clock); #1;
    chk("valid_clr", 32'(Out_Valid), 32'd0);
    chk("illegal_clr", 32'(Illegal), 32'd0);
    chk("divzero_clr", 32'(Div_Zero), 32'd0);
    chk("op_held", 32'(ALU_Op), 32'(eop));
    Out_Ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    Reset = 1'b1; Instr_Valid = 1'b0; Out_Ready = 1'b0;
    Opcode = '0; Reg_Data_1 = '0; Reg_Data_2 = '0; Imm = '0;
    repeat (2) @(posedge Fast_Clock);
    #1;
    chk("rst_op", 32'(ALU_Op), 32'd17);
    chk("rst_d1", Data_1, 32'd0);
    chk("rst_d2", Data_2, 32'd0);
    chk("rst_wb", Wb_Data, 32'd0);
    chk("rst_flags", {27'd0, Out_Valid, Wb_En, Branch_Taken, Illegal, Div_Zero}, 32'd0);
    chk("rst_ready", 32'(Instr_Ready), 32'd0);
    Reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(Instr_Ready), 32'd1);
    @(posedge Fast_Clock); #1;

    do_instr(6'd32, 5, 0, 16'hFFFD, 0);
    chk("addi_const", last_wb, 32'd2);
    do_instr(6'd3, -7, 2, 16'h0, 0);
    chk("div_const", last_wb, -32'sd3);
    do_instr(6'd16, 1, 4, 16'h0, 0);
    chk("lt_const", last_wb, 32'd1);
    do_instr(6'd20, 3, 4, 16'h0, 0);
    repeat (3) begin
      @(posedge Fast_Clock); #1;
      chk("illegal_single", 32'(Out_Valid), 32'd0);
    end
    do_instr(6'd2, 3, 4, 16'h0, 5);
    do_instr(6'd4, 9, 0, 16'h0, 1);
    do_instr(6'd48, 77, 1, 16'h8001, 0);
    do_instr(6'd63, 1, 2, 16'h0, 2);

    // Reset pulsed while a MUL waits in EXEC
    Instr_Valid = 1'b1; Opcode = 6'd2; Reg_Data_1 = 6; Reg_Data_2 = 7;
    @(posedge Fast_Clock); #1;
    Instr_Valid = 1'b0;
    @(posedge Fast_Clock); #1;
    Reset = 1'b1;
    #1;
    chk("midrst_op", 32'(ALU_Op), 32'd17);
    chk("midrst_d1", Data_1, 32'd0);
    chk("midrst_valid", 32'(Out_Valid), 32'd0);
    @(posedge Fast_Clock); #1;
    Reset = 1'b0;
    repeat (LAT + 3) begin
      @(posedge Fast_Clock); #1;
      chk("midrst_no_valid", 32'(Out_Valid), 32'd0);
    end
    chk("midrst_ready", 32'(Instr_Ready), 32'd1);

    for (int i = 0; i < 150; i++) begin
      logic [5:0] opc;
      logic signed [31:0] a, b;
      opc = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) opc = 6'($urandom_range(0, 16));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      if ($urandom_range(0, 1) == 0) begin a = a >>> 20; b = b >>> 24; end
      do_instr(opc, a, b, 16'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
